// File: rtl/wbtriarb.sv
// wbtriarb: three-master Wishbone arbiter (A = data memory, B = instruction
// fetch, C = debug/DMA) sharing one pipelined bus with separate global and
// local cycle/strobe lines. Ownership is registered and changes only while
// the current owner holds both cycle lines low. An outstanding-request
// counter throttles the owner and discards stale acknowledgements.
module wbtriarb #(
  parameter int AW             = 30,
  parameter int DW             = 32,
  parameter int LGOUT          = 4,
  parameter bit OPT_ROUNDROBIN = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  // master A
  input  logic            i_a_cyc_gbl,
  input  logic            i_a_cyc_lcl,
  input  logic            i_a_stb_gbl,
  input  logic            i_a_stb_lcl,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  output logic            o_a_stall,
  output logic            o_a_ack,
  output logic            o_a_err,
  // master B
  input  logic            i_b_cyc_gbl,
  input  logic            i_b_cyc_lcl,
  input  logic            i_b_stb_gbl,
  input  logic            i_b_stb_lcl,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_stall,
  output logic            o_b_ack,
  output logic            o_b_err,
  // master C
  input  logic            i_c_cyc_gbl,
  input  logic            i_c_cyc_lcl,
  input  logic            i_c_stb_gbl,
  input  logic            i_c_stb_lcl,
  input  logic            i_c_we,
  input  logic [AW-1:0]   i_c_addr,
  input  logic [DW-1:0]   i_c_data,
  input  logic [DW/8-1:0] i_c_sel,
  output logic            o_c_stall,
  output logic            o_c_ack,
  output logic            o_c_err,
  // shared bus
  output logic            o_cyc_gbl,
  output logic            o_cyc_lcl,
  output logic            o_stb_gbl,
  output logic            o_stb_lcl,
  output logic            o_we,
  output logic [AW-1:0]   o_addr,
  output logic [DW-1:0]   o_data,
  output logic [DW/8-1:0] o_sel,
  input  logic            i_stall,
  input  logic            i_ack,
  input  logic            i_err,
  // status
  output logic [1:0]      o_owner,
  output logic            o_busy
);

  localparam logic [LGOUT-1:0] CNT_ZERO = {LGOUT{1'b0}};
  localparam logic [LGOUT-1:0] CNT_ONE  = {{(LGOUT-1){1'b0}}, 1'b1};
  localparam logic [LGOUT-1:0] CNT_MAX  = {LGOUT{1'b1}};

  logic [1:0]       owner_q, owner_d;
  logic [LGOUT-1:0] cnt_q, cnt_d;
  logic [3:0]       req_s;
  logic             owner_act_s, throttle_s, own_stb_gbl_s, own_stb_lcl_s;
  logic             inc_s, dec_s, own_stall_s, own_ack_s, own_err_s;

  // Step an owner index through 0,1,2 cyclically.
  function automatic logic [1:0] inc3(input logic [1:0] cur);
    logic [1:0] nxt;
    case (cur)
      2'd0:    nxt = 2'd1;
      2'd1:    nxt = 2'd2;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

  // Fixed priority A > B > C; park on the current owner when nobody asks.
  function automatic logic [1:0] pick_fixed(input logic [1:0] cur, input logic [3:0] req);
    logic [1:0] sel;
    if (req[0])      sel = 2'd0;
    else if (req[1]) sel = 2'd1;
    else if (req[2]) sel = 2'd2;
    else             sel = cur;
    return sel;
  endfunction

  // Round-robin: first requester in order cur+1, cur+2, cur (mod 3).
  function automatic logic [1:0] pick_rr(input logic [1:0] cur, input logic [3:0] req);
    logic [1:0] idx;
    logic [1:0] sel;
    logic       found;
    idx   = cur;
    sel   = cur;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idx = inc3(idx);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  assign req_s = {1'b0,
                  i_c_cyc_gbl | i_c_cyc_lcl,
                  i_b_cyc_gbl | i_b_cyc_lcl,
                  i_a_cyc_gbl | i_a_cyc_lcl};

  // Route the owner's request lines onto the shared bus.
  always_comb begin
    o_cyc_gbl     = 1'b0;
    o_cyc_lcl     = 1'b0;
    own_stb_gbl_s = 1'b0;
    own_stb_lcl_s = 1'b0;
    o_we          = 1'b0;
    o_addr        = {AW{1'b0}};
    o_data        = {DW{1'b0}};
    o_sel         = {(DW/8){1'b0}};
    case (owner_q)
      2'd0: begin
        o_cyc_gbl = i_a_cyc_gbl; o_cyc_lcl = i_a_cyc_lcl;
        own_stb_gbl_s = i_a_stb_gbl; own_stb_lcl_s = i_a_stb_lcl;
        o_we = i_a_we; o_addr = i_a_addr; o_data = i_a_data; o_sel = i_a_sel;
      end
      2'd1: begin
        o_cyc_gbl = i_b_cyc_gbl; o_cyc_lcl = i_b_cyc_lcl;
        own_stb_gbl_s = i_b_stb_gbl; own_stb_lcl_s = i_b_stb_lcl;
        o_we = i_b_we; o_addr = i_b_addr; o_data = i_b_data; o_sel = i_b_sel;
      end
      2'd2: begin
        o_cyc_gbl = i_c_cyc_gbl; o_cyc_lcl = i_c_cyc_lcl;
        own_stb_gbl_s = i_c_stb_gbl; own_stb_lcl_s = i_c_stb_lcl;
        o_we = i_c_we; o_addr = i_c_addr; o_data = i_c_data; o_sel = i_c_sel;
      end
      default: begin
        o_cyc_gbl = 1'b0;
      end
    endcase
  end

  assign owner_act_s = o_cyc_gbl | o_cyc_lcl;
  assign throttle_s  = (cnt_q == CNT_MAX);
  assign o_stb_gbl   = own_stb_gbl_s & !throttle_s;
  assign o_stb_lcl   = own_stb_lcl_s & !throttle_s;
  assign inc_s       = (o_stb_gbl | o_stb_lcl) & !i_stall;
  assign dec_s       = i_ack & (cnt_q != CNT_ZERO);
  assign own_stall_s = i_stall | throttle_s;
  assign own_ack_s   = dec_s;
  assign own_err_s   = i_err & owner_act_s;

  // Return stall/ack/err to the owner; everyone else is held stalled.
  always_comb begin
    o_a_stall = 1'b1; o_a_ack = 1'b0; o_a_err = 1'b0;
    o_b_stall = 1'b1; o_b_ack = 1'b0; o_b_err = 1'b0;
    o_c_stall = 1'b1; o_c_ack = 1'b0; o_c_err = 1'b0;
    case (owner_q)
      2'd0: begin o_a_stall = own_stall_s; o_a_ack = own_ack_s; o_a_err = own_err_s; end
      2'd1: begin o_b_stall = own_stall_s; o_b_ack = own_ack_s; o_b_err = own_err_s; end
      2'd2: begin o_c_stall = own_stall_s; o_c_ack = own_ack_s; o_c_err = own_err_s; end
      default: begin o_a_stall = 1'b1; end
    endcase
  end

  // Next owner: re-arbitrate only while the current owner is idle.
  always_comb begin
    owner_d = owner_q;
    if (!owner_act_s) begin
      if (OPT_ROUNDROBIN) owner_d = pick_rr(owner_q, req_s);
      else                owner_d = pick_fixed(owner_q, req_s);
    end else begin
      owner_d = owner_q;
    end
  end

  // Next outstanding count; an idle owner or a bus error aborts everything.
  always_comb begin
    cnt_d = cnt_q;
    if (!owner_act_s || i_err)  cnt_d = CNT_ZERO;
    else if (inc_s && !dec_s)   cnt_d = cnt_q + CNT_ONE;
    else if (dec_s && !inc_s)   cnt_d = cnt_q - CNT_ONE;
    else                        cnt_d = cnt_q;
  end

  // Ownership and outstanding-count registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      owner_q <= 2'd0;
      cnt_q   <= CNT_ZERO;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_owner = owner_q;
  assign o_busy  = (cnt_q != CNT_ZERO);

endmodule

// File: tb/tb_wbtriarb.sv
// Directed bench for wbtriarb. Three instances share one stimulus:
// [0] fixed priority, [1] round-robin, [2] fixed priority with LGOUT=2.
module tb_wbtriarb;
  localparam int AW = 30;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic i_reset;
  logic a_cyc_gbl, a_cyc_lcl, a_stb_gbl, a_stb_lcl, a_we;
  logic b_cyc_gbl, b_cyc_lcl, b_stb_gbl, b_stb_lcl, b_we;
  logic c_cyc_gbl, c_cyc_lcl, c_stb_gbl, c_stb_lcl, c_we;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic [DW-1:0] a_data, b_data, c_data;
  logic [DW/8-1:0] a_sel, b_sel, c_sel;
  logic i_stall, i_ack, i_err;

  logic a_stall [3], a_ack [3], a_err [3];
  logic b_stall [3], b_ack [3], b_err [3];
  logic c_stall [3], c_ack [3], c_err [3];
  logic cyc_gbl [3], cyc_lcl [3], stb_gbl [3], stb_lcl [3], we [3];
  logic [AW-1:0] addr [3];
  logic [DW-1:0] data [3];
  logic [DW/8-1:0] sel [3];
  logic [1:0] owner [3];
  logic busy [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wbtriarb #(
      .AW(AW), .DW(DW),
      .LGOUT((g == 2) ? 2 : 4),
      .OPT_ROUNDROBIN(g == 1)
    ) u_dut (
      .i_clk(clk), .i_reset(i_reset),
      .i_a_cyc_gbl(a_cyc_gbl), .i_a_cyc_lcl(a_cyc_lcl), .i_a_stb_gbl(a_stb_gbl),
      .i_a_stb_lcl(a_stb_lcl), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_data),
      .i_a_sel(a_sel), .o_a_stall(a_stall[g]), .o_a_ack(a_ack[g]), .o_a_err(a_err[g]),
      .i_b_cyc_gbl(b_cyc_gbl), .i_b_cyc_lcl(b_cyc_lcl), .i_b_stb_gbl(b_stb_gbl),
      .i_b_stb_lcl(b_stb_lcl), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_data(b_data),
      .i_b_sel(b_sel), .o_b_stall(b_stall[g]), .o_b_ack(b_ack[g]), .o_b_err(b_err[g]),
      .i_c_cyc_gbl(c_cyc_gbl), .i_c_cyc_lcl(c_cyc_lcl), .i_c_stb_gbl(c_stb_gbl),
      .i_c_stb_lcl(c_stb_lcl), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_data(c_data),
      .i_c_sel(c_sel), .o_c_stall(c_stall[g]), .o_c_ack(c_ack[g]), .o_c_err(c_err[g]),
      .o_cyc_gbl(cyc_gbl[g]), .o_cyc_lcl(cyc_lcl[g]), .o_stb_gbl(stb_gbl[g]),
      .o_stb_lcl(stb_lcl[g]), .o_we(we[g]), .o_addr(addr[g]), .o_data(data[g]),
      .o_sel(sel[g]), .i_stall(i_stall), .i_ack(i_ack), .i_err(i_err),
      .o_owner(owner[g]), .o_busy(busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling (well before the next edge).
  task automatic settle();
    #2;
  endtask

  task automatic idle_all();
    a_cyc_gbl = 1'b0; a_cyc_lcl = 1'b0; a_stb_gbl = 1'b0; a_stb_lcl = 1'b0;
    b_cyc_gbl = 1'b0; b_cyc_lcl = 1'b0; b_stb_gbl = 1'b0; b_stb_lcl = 1'b0;
    c_cyc_gbl = 1'b0; c_cyc_lcl = 1'b0; c_stb_gbl = 1'b0; c_stb_lcl = 1'b0;
    i_stall = 1'b0; i_ack = 1'b0; i_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    i_reset = 1'b1;
    next_cyc();
    i_reset = 1'b0;
  endtask

  initial begin
    logic [3:0] exp1 [7];
    logic [1:0] exp3 [6];
    exp1[0] = 4'd0; exp1[1] = 4'd1; exp1[2] = 4'd2; exp1[3] = 4'd3;
    exp1[4] = 4'd2; exp1[5] = 4'd1; exp1[6] = 4'd0;
    exp3[0] = 2'd0; exp3[1] = 2'd1; exp3[2] = 2'd2; exp3[3] = 2'd3;
    exp3[4] = 2'd2; exp3[5] = 2'd3;

    a_we = 1'b0; b_we = 1'b0; c_we = 1'b0;
    a_addr = 30'h0AA; b_addr = 30'h100; c_addr = 30'h0CC;
    a_data = 32'h1111_1111; b_data = 32'h2222_2222; c_data = 32'h3333_3333;
    a_sel = 4'hF; b_sel = 4'hF; c_sel = 4'hF;
    idle_all();
    i_reset = 1'b1;
    next_cyc();
    next_cyc();
    i_reset = 1'b0;
    settle();

    // Reset state
    chk("rst_owner", 32'(owner[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_b_stall", 32'(b_stall[0]), 32'd1);
    chk("rst_c_stall", 32'(c_stall[0]), 32'd1);
    chk("rst_a_ack", 32'(a_ack[0]), 32'd0);
    chk("rst_cyc", 32'(cyc_gbl[0]), 32'd0);
    chk("rst_addr", 32'(addr[0]), 32'h0AA);

    // Three pipelined reads from A, acks three cycles after each strobe
    for (int k = 0; k < 7; k++) begin
      if (k > 0) next_cyc();
      a_cyc_gbl = (k < 6);
      a_stb_gbl = (k < 3);
      i_ack     = (k >= 3) && (k < 6);
      settle();
      chk("t1_cnt", 32'(g_dut[0].u_dut.cnt_q), 32'(exp1[k]));
      chk("t1_a_ack", 32'(a_ack[0]), ((k >= 3) && (k < 6)) ? 32'd1 : 32'd0);
      chk("t1_stb", 32'(stb_gbl[0]), (k < 3) ? 32'd1 : 32'd0);
      chk("t1_b_stall", 32'(b_stall[0]), 32'd1);
      chk("t1_owner", 32'(owner[0]), 32'd0);
    end
    i_ack = 1'b0;

    // B requests while A idle: granted next cycle
    next_cyc();
    b_cyc_gbl = 1'b1; b_stb_gbl = 1'b1;
    settle();
    chk("t2_owner_t", 32'(owner[0]), 32'd0);
    chk("t2_b_stall_t", 32'(b_stall[0]), 32'd1);
    chk("t2_stb_t", 32'(stb_gbl[0]), 32'd0);
    next_cyc();
    settle();
    chk("t2_owner_t1", 32'(owner[0]), 32'd1);
    chk("t2_stb_t1", 32'(stb_gbl[0]), 32'd1);
    chk("t2_addr_t1", 32'(addr[0]), 32'h100);
    chk("t2_b_stall_t1", 32'(b_stall[0]), 32'd0);
    chk("t2_rr_owner_t1", 32'(owner[1]), 32'd1);

    // B releases while A and C both request: RR picks C, fixed picks A
    next_cyc();
    b_cyc_gbl = 1'b0; b_stb_gbl = 1'b0;
    a_cyc_gbl = 1'b1; c_cyc_gbl = 1'b1;
    settle();
    chk("t3_owner_hold", 32'(owner[1]), 32'd1);
    next_cyc();
    settle();
    chk("t3_fp_owner", 32'(owner[0]), 32'd0);
    chk("t3_rr_owner", 32'(owner[1]), 32'd2);
    chk("t3_rr_c_stall", 32'(c_stall[1]), 32'd0);

    // LGOUT=2 throttling on instance 2
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cyc();
      a_cyc_gbl = 1'b1; a_stb_gbl = 1'b1;
      i_ack = (k == 3);
      settle();
      chk("t4_cnt", 32'(g_dut[2].u_dut.cnt_q), 32'(exp3[k]));
      chk("t4_stb", 32'(stb_gbl[2]), ((k == 3) || (k == 5)) ? 32'd0 : 32'd1);
      chk("t4_a_stall", 32'(a_stall[2]), ((k == 3) || (k == 5)) ? 32'd1 : 32'd0);
      chk("t4_a_ack", 32'(a_ack[2]), (k == 3) ? 32'd1 : 32'd0);
    end

    // Bus error with cnt=2: one err, counter clears, later ack dropped
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next_cyc();
      a_cyc_gbl = 1'b1;
      a_stb_gbl = (k < 2);
      i_err = (k == 2);
      i_ack = (k == 3);
      settle();
      chk("t5_a_err", 32'(a_err[0]), (k == 2) ? 32'd1 : 32'd0);
      chk("t5_a_ack", 32'(a_ack[0]), 32'd0);
      chk("t5_cnt", 32'(g_dut[0].u_dut.cnt_q), (k == 3) ? 32'd0 : 32'(k));
    end

    // Reset while C owns the bus with cnt=2
    do_reset();
    c_cyc_gbl = 1'b1; c_stb_gbl = 1'b1;
    next_cyc();
    settle();
    chk("t6_owner_c", 32'(owner[0]), 32'd2);
    next_cyc();
    next_cyc();
    c_stb_gbl = 1'b0;
    i_reset = 1'b1;
    settle();
    chk("t6_cnt_pre", 32'(g_dut[0].u_dut.cnt_q), 32'd2);
    next_cyc();
    i_reset = 1'b0;
    i_ack = 1'b1;
    settle();
    chk("t6_owner_rst", 32'(owner[0]), 32'd0);
    chk("t6_cnt_rst", 32'(g_dut[0].u_dut.cnt_q), 32'd0);
    chk("t6_c_stall", 32'(c_stall[0]), 32'd1);
    chk("t6_c_ack", 32'(c_ack[0]), 32'd0);
    chk("t6_a_ack", 32'(a_ack[0]), 32'd0);
    next_cyc();
    settle();
    chk("t6_owner_regrant", 32'(owner[0]), 32'd2);
    chk("t6_c_ack_stale", 32'(c_ack[0]), 32'd0);
    idle_all();
    next_cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
